// File: rtl/pipe_src_if.sv
// Upstream valid/ready bus feeding pipe_src: one sample pair plus its correction factor per beat.
interface pipe_src_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data0;
  logic [15:0] s_data1;
  logic [1:0]  s_cf;

  modport master (output s_valid, output s_data0, output s_data1, output s_cf, input s_ready);
  modport slave  (input s_valid, input s_data0, input s_data1, input s_cf, output s_ready);
endinterface

// File: rtl/pipe_src.sv
// FIFO feeder for the two-lane correction pipe; issues one entry per cycle with a 2-cycle-delayed valid strobe.
// Define PIPE_SRC_STATS_EN to build the saturating issued-entry counter on o_sent_cnt.
module pipe_src #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pipe_src_if.slave                s_if,
  input  logic                     i_hold,
  output logic                     o_en,
  output logic [1:0]               o_cf,
  output logic [15:0]              o_data0,
  output logic [15:0]              o_data1,
  output logic                     o_pipe_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [15:0]              o_sent_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [33:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_en;
  logic [1:0]    r_cf;
  logic [15:0]   r_data0;
  logic [15:0]   r_data1;
  logic [1:0]    r_pv;

  logic          w_push;
  logic          w_pop;
  logic          w_ready;
  logic [33:0]   w_rd_entry;

  // Full/empty come from the count so pointer equality never has to be disambiguated.
  assign w_ready    = (r_count != CW'(DEPTH));
  assign w_push     = s_if.s_valid && w_ready;
  assign w_pop      = (r_count != '0) && !i_hold;
  assign w_rd_entry = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_if.s_cf, s_if.s_data1, s_if.s_data0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register holds the last issued entry while o_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_cf    <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_pv    <= '0;
    end else begin
      r_en <= w_pop;
      r_pv <= {r_pv[0], r_en};
      if (w_pop) begin
        r_cf    <= w_rd_entry[33:32];
        r_data1 <= w_rd_entry[31:16];
        r_data0 <= w_rd_entry[15:0];
      end
    end
  end

`ifdef PIPE_SRC_STATS_EN
  logic [15:0] r_sent_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sent_cnt <= '0;
    end else if (w_pop && (r_sent_cnt != 16'hFFFF)) begin
      r_sent_cnt <= r_sent_cnt + 16'd1;
    end
  end

  assign o_sent_cnt = r_sent_cnt;
`else
  assign o_sent_cnt = 16'h0000;
`endif

  assign s_if.s_ready = w_ready;
  assign o_en         = r_en;
  assign o_cf         = r_cf;
  assign o_data0      = r_data0;
  assign o_data1      = r_data1;
  assign o_pipe_valid = r_pv[1];
  assign o_count      = r_count;
endmodule

// File: tb/tb_pipe_src.sv
// Scoreboard bench for pipe_src: cycle-accurate model checked on every falling edge.
module tb_pipe_src;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        i_hold;
  logic        o_en;
  logic [1:0]  o_cf;
  logic [15:0] o_data0;
  logic [15:0] o_data1;
  logic        o_pipe_valid;
  logic [2:0]  o_count;
  logic [15:0] o_sent_cnt;

  pipe_src_if u_if ();

  pipe_src #(.DEPTH(DEPTH)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (u_if),
    .i_hold       (i_hold),
    .o_en         (o_en),
    .o_cf         (o_cf),
    .o_data0      (o_data0),
    .o_data1      (o_data1),
    .o_pipe_valid (o_pipe_valid),
    .o_count      (o_count),
    .o_sent_cnt   (o_sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [33:0] sb_q[$];
  logic [33:0] last_exp;
  logic [33:0] cur;
  logic        pred_en;
  logic        e1;
  logic        e2;
  logic [15:0] exp_sent;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_en", o_en, 0);
      chk("rst_pv", o_pipe_valid, 0);
      chk("rst_data", {o_cf, o_data1, o_data0}, 0);
      chk("rst_count", o_count, 0);
      chk("rst_ready", u_if.s_ready, 1);
      chk("rst_sent", o_sent_cnt, 0);
      sb_q.delete();
      last_exp = '0;
      pred_en  = 1'b0;
      e1       = 1'b0;
      e2       = 1'b0;
      exp_sent = '0;
    end else begin
      chk("en", o_en, pred_en);
      chk("pipe_valid", o_pipe_valid, e2);
      e2 = e1;
      e1 = pred_en;
      if (o_en) begin
        if (sb_q.size() == 0) begin
          chk("underflow", 1, 0);
        end else begin
          cur = sb_q.pop_front();
          chk("issue", {o_cf, o_data1, o_data0}, cur);
          last_exp = cur;
        end
`ifdef PIPE_SRC_STATS_EN
        if (exp_sent != 16'hFFFF) exp_sent = exp_sent + 16'd1;
`endif
      end else begin
        chk("hold_data", {o_cf, o_data1, o_data0}, last_exp);
      end
      chk("count", o_count, sb_q.size());
      chk("ready", u_if.s_ready, sb_q.size() != DEPTH);
      chk("sent", o_sent_cnt, exp_sent);
      pred_en = (sb_q.size() != 0) && !i_hold;
      if (u_if.s_valid && u_if.s_ready) begin
        sb_q.push_back({u_if.s_cf, u_if.s_data1, u_if.s_data0});
      end
    end
  end

  task automatic push_one(input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] cf);
    logic acc;
    int   n;
    u_if.s_valid = 1'b1;
    u_if.s_data0 = d0;
    u_if.s_data1 = d1;
    u_if.s_cf    = cf;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = u_if.s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("push_timeout", 0, 1);
    u_if.s_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || o_count != 0 || o_en) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) chk("drain_timeout", 1, 0);
    idle(3);
  endtask

  initial begin
    rst_n        = 1'b0;
    i_hold       = 1'b0;
    u_if.s_valid = 1'b0;
    u_if.s_data0 = '0;
    u_if.s_data1 = '0;
    u_if.s_cf    = '0;
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single entry
    push_one(16'h0003, 16'h0010, 2'd2);
    wait_empty();

    // fill to full, refuse the fifth, then drain
    i_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_one(16'h0100 + 16'(i), 16'h0200 + 16'(i), 2'(i));
    u_if.s_valid = 1'b1;
    u_if.s_data0 = 16'h0BAD;
    u_if.s_data1 = 16'h0BAD;
    u_if.s_cf    = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", u_if.s_ready, 0);
      chk("full_count", o_count, 4);
      @(posedge clk);
      #1;
    end
    u_if.s_valid = 1'b0;
    i_hold = 1'b0;
    wait_empty();

    // stream across pointer wrap
    for (int i = 0; i < 10; i++) push_one(16'h1000 + 16'(i), 16'h2000 + 16'(i), 2'(i));
    wait_empty();

    // hold for three edges mid-burst
    for (int i = 0; i < 8; i++) begin
      if (i == 3) i_hold = 1'b1;
      if (i == 6) i_hold = 1'b0;
      push_one(16'h3000 + 16'(i), 16'h4000 + 16'(i), 2'(3 - i));
    end
    wait_empty();

    // reset while entries are queued and o_en is high
    i_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_one(16'h5000 + 16'(i), 16'h6000 + 16'(i), 2'd1);
    i_hold = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_en", o_en, 1);
    chk("pre_rst_count", o_count, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_en", o_en, 0);
    chk("arst_data", {o_cf, o_data1, o_data0}, 0);
    chk("arst_count", o_count, 0);
    chk("arst_ready", u_if.s_ready, 1);
    idle(2);
    rst_n = 1'b1;
    idle(4);

    // boundary sample values
    push_one(16'hFFFF, 16'h0000, 2'd3);
    wait_empty();

    // randomized traffic with random stalls
    for (int i = 0; i < 300; i++) begin
      u_if.s_valid = 1'($urandom_range(0, 1));
      u_if.s_data0 = 16'($urandom);
      u_if.s_data1 = 16'($urandom);
      u_if.s_cf    = 2'($urandom);
      i_hold       = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    u_if.s_valid = 1'b0;
    i_hold       = 1'b0;
    wait_empty();

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
